sdiv_sequencer: RTL and testbench

- Signed front-end placed directly upstream of the team's unsigned iterative divider (the `div` block).
- Accepts a signed 32-bit divide request, converts both operands to magnitudes and launches the divider with a one-cycle start pulse.
- Waits for the divider's ready signal, then sign-corrects the quotient and presents a registered result with a one-cycle ready pulse.
- Also flags divide-by-zero and the INT_MIN / -1 overflow; neither case launches the divider.

---
 rtl/sdiv_pkg.sv | 16 +
 rtl/sign_mag32.sv | 10 +
 rtl/sdiv_sequencer.sv | 144 ++++++++++++++
 tb/tb_sdiv_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sdiv_pkg.sv
// Shared types and constants for the signed divide front-end (sdiv_sequencer).
package sdiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FIX,
    DONE
  } state_e;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;
  localparam int DIV_TIMEOUT_DEF = 64;

endpackage

// File: rtl/sign_mag32.sv
// Conditional 32-bit two's-complement negate; 0x80000000 negates to itself.
module sign_mag32 (
  input  logic [31:0] in_i,
  input  logic        neg_i,
  output logic [31:0] out_o
);

  assign out_o = neg_i ? (~in_i + 32'd1) : in_i;

endmodule

// File: rtl/sdiv_sequencer.sv
// Signed front-end for the unsigned iterative divider: magnitude conversion,
// launch, sign fix-up and exception flags. SDIV_WATCHDOG_EN adds a WAIT timeout.
module sdiv_sequencer
  import sdiv_pkg::*;
#(
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [31:0] div_operandA,
  output logic [31:0] div_operandB,
  output logic        div_start,
  input  logic [31:0] div_result,
  input  logic        div_resultRDY,
  input  logic        div_exception
);

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] quo_q, quo_d;
  logic        dexc_q, dexc_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;
  logic        rdy_q;
  logic        first_q;
  logic        timeout;

  logic [31:0] mag_a, mag_b, fix_res;

  sign_mag32 u_mag_a (.in_i(data_operandA), .neg_i(data_operandA[31]), .out_o(mag_a));
  sign_mag32 u_mag_b (.in_i(data_operandB), .neg_i(data_operandB[31]), .out_o(mag_b));
  sign_mag32 u_fix   (.in_i(quo_q),         .neg_i(sign_q),            .out_o(fix_res));

`ifdef SDIV_WATCHDOG_EN
  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  // Counts completed WAIT cycles; cleared while launching.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              cnt_q <= '0;
    else if (state_q == LAUNCH) cnt_q <= '0;
    else if (state_q == WAIT)   cnt_q <= cnt_q + CW'(1);
  end

  assign timeout = (cnt_q == CW'(DIV_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    quo_d   = quo_q;
    dexc_d  = dexc_q;
    res_d   = res_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: begin
        if (ctrl_DIV) begin
          sign_d = data_operandA[31] ^ data_operandB[31];
          opa_d  = mag_a;
          opb_d  = mag_b;
          if (data_operandB == '0) begin
            res_d   = '0;
            exc_d   = 1'b1;
            state_d = DONE;
          end else if (data_operandA == INT_MIN && data_operandB == NEG_ONE) begin
            res_d   = INT_MIN;
            exc_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        // A ready seen in the first WAIT cycle may belong to a previous operation.
        if (!first_q && div_resultRDY) begin
          quo_d   = div_result;
          dexc_d  = div_exception;
          state_d = FIX;
        end else if (timeout) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = DONE;
        end
      end
      FIX: begin
        res_d   = fix_res;
        exc_d   = dexc_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      quo_q   <= '0;
      dexc_q  <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      quo_q   <= quo_d;
      dexc_q  <= dexc_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= (state_q == DONE);
      first_q <= (state_q == LAUNCH);
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != IDLE);
  assign div_operandA   = opa_q;
  assign div_operandB   = opb_q;
  assign div_start      = (state_q == LAUNCH);

endmodule

// File: tb/tb_sdiv_sequencer.sv
// Directed plus randomized bench for sdiv_sequencer with a behavioural divider model.
module tb_sdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  logic [31:0] div_operandA, div_operandB;
  logic        div_start;
  logic [31:0] div_result;
  logic        div_resultRDY, div_exception;

  int errors = 0;
  int checks = 0;

  int m_lat   = 2;
  bit m_stale = 1'b0;
  bit m_dexc  = 1'b0;
  bit m_hold  = 1'b0;
  int mcnt;

  always #5 clock = ~clock;

  sdiv_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .div_operandA   (div_operandA),
    .div_operandB   (div_operandB),
    .div_start      (div_start),
    .div_result     (div_result),
    .div_resultRDY  (div_resultRDY),
    .div_exception  (div_exception)
  );

  // Unsigned divider model: ready is sampled m_lat edges after the start is sampled.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_resultRDY <= 1'b0;
      div_result    <= '0;
      div_exception <= 1'b0;
      mcnt          <= 0;
    end else begin
      div_resultRDY <= 1'b0;
      div_exception <= 1'b0;
      if (div_start) begin
        mcnt <= m_lat - 1;
        if (m_stale) begin
          div_resultRDY <= 1'b1;
          div_result    <= 32'hDEAD_BEEF;
          div_exception <= 1'b1;
        end
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && !m_hold) begin
          div_resultRDY <= 1'b1;
          div_result    <= (div_operandB == 0) ? 32'd0 : div_operandA / div_operandB;
          div_exception <= m_dexc;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic e);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; e = 1'b1;
    end else begin
      q = sa / sb; e = 1'b0;
    end
  endfunction

  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input int lat,
                         input bit stale, input bit dexc, input bit mid, input bit hold,
                         input string tag);
    logic [31:0] q, ma, mb, sa, sb;
    logic        e;
    bit          launched;
    int          k, nstart, expk;
    ref_div(a, b, q, e);
    launched = !e;
    if (launched && hold) begin q = 32'd0; e = 1'b1; end
    else if (launched && dexc) e = 1'b1;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    expk = !launched ? 2 : (hold ? 64 + 3 : lat + 4);
    m_lat = lat; m_stale = stale; m_dexc = dexc; m_hold = hold;
    data_operandA = a; data_operandB = b; ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    k = 1; nstart = 0; sa = '0; sb = '0;
    while (!data_resultRDY && k < 300) begin
      if (div_start) begin nstart++; sa = div_operandA; sb = div_operandB; end
      if (mid && k == 3) begin
        ctrl_DIV = 1'b1; data_operandA = 32'd999; data_operandB = 32'd3;
      end else ctrl_DIV = 1'b0;
      @(posedge clock); #1;
      k++;
    end
    ctrl_DIV = 1'b0;
    chk({tag, "_latency"}, 32'(k), 32'(expk));
    chk({tag, "_starts"}, 32'(nstart), launched ? 32'd1 : 32'd0);
    chk({tag, "_result"}, data_result, q);
    chk({tag, "_exc"}, {31'd0, data_exception}, {31'd0, e});
    if (launched) begin
      chk({tag, "_opA"}, sa, ma);
      chk({tag, "_opB"}, sb, mb);
    end
    @(posedge clock); #1;
    chk({tag, "_pulse_end"}, {31'd0, data_resultRDY}, 32'd0);
    chk({tag, "_hold"}, data_result, q);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          sel;
    reset_n = 1'b0; ctrl_DIV = 1'b0; data_operandA = '0; data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_result", data_result, 32'd0);
    chk("rst_exc", {31'd0, data_exception}, 32'd0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, div_start}, 32'd0);
    chk("rst_opA", div_operandA, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_req(32'd100, 32'd7, 5, 0, 0, 0, 0, "pos");
    run_req(-32'd100, 32'd7, 3, 0, 0, 0, 0, "negA");
    run_req(-32'd7, -32'd2, 2, 1, 0, 0, 0, "negAB_stale");
    run_req(-32'd7, 32'd2, 6, 1, 0, 0, 0, "trunc");
    run_req(32'd7, 32'd0, 4, 0, 0, 0, 0, "divzero");
    run_req(32'h8000_0000, 32'hFFFF_FFFF, 4, 0, 0, 0, 0, "ovf");
    run_req(32'h8000_0000, 32'd2, 4, 0, 0, 0, 0, "intmin2");
    run_req(32'd20, -32'd3, 4, 0, 1, 0, 0, "divexc");
    run_req(32'd100, 32'd7, 8, 0, 0, 1, 0, "midreq");

    // Reset asserted while waiting on the divider.
    data_operandA = -32'd50; data_operandB = 32'd5; m_lat = 8; m_stale = 0; m_dexc = 0;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_result", data_result, 32'd0);
    chk("arst_exc", {31'd0, data_exception}, 32'd0);
    chk("arst_start", {31'd0, div_start}, 32'd0);
    chk("arst_opA", div_operandA, 32'd0);
    chk("arst_opB", div_operandB, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("arst_nordy", {31'd0, data_resultRDY}, 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_rdy", {31'd0, data_resultRDY}, 32'd0);

    for (int i = 0; i < 25; i++) begin
      sel = $urandom_range(0, 5);
      ra  = $urandom;
      case (sel)
        0: rb = 32'd0;
        1: begin
          rb = 32'hFFFF_FFFF;
          if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000;
        end
        2: begin
          rb = 32'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        default: rb = $urandom;
      endcase
      run_req(ra, rb, $urandom_range(2, 7), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), 0, 0, "rand");
    end

`ifdef SDIV_WATCHDOG_EN
    run_req(32'd5, 32'd1, 4, 0, 0, 0, 1, "wdog");
    run_req(32'd9, 32'd3, 3, 0, 0, 0, 0, "after_wdog");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
